stopwatch_ctrl: RTL and testbench

//  Stopwatch sequencer for the divided-clock/7-seg datapath.

---
 rtl/stopwatch_ctrl_if.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Handshake-free control/display bundle for the stopwatch sequencer.
// Master drives button/tick pulses; slave returns display and status.
interface stopwatch_ctrl_if;
   logic        tick;
   logic        start_stop;
   logic        lap_reset;
   logic [15:0] disp_bcd;
   logic        run;
   logic        lap_frozen;
   logic [1:0]  state;
   logic        wrap;

   modport master (
      output tick,
      output start_stop,
      output lap_reset,
      input  disp_bcd,
      input  run,
      input  lap_frozen,
      input  state,
      input  wrap
   );

   modport slave (
      input  tick,
      input  start_stop,
      input  lap_reset,
      output disp_bcd,
      output run,
      output lap_frozen,
      output state,
      output wrap
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE/LAP FSM gating a BCD mm:ss counter
// with tick prescaler, lap freeze register and rollover pulse.
module stopwatch_ctrl #(
   parameter int unsigned MIN_MAX       = 59,
   parameter int unsigned TICK_PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   stopwatch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_e;

   localparam logic [7:0] PRE_LAST = 8'(TICK_PRESCALE - 1);
   localparam logic [7:0] MIN_BCD  = {4'(MIN_MAX / 10),
                                      4'(MIN_MAX % 10)};

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lap_q, lap_d;
   logic [7:0]  pre_q, pre_d;
   logic [15:0] disp_q, disp_d;
   logic        run_q, run_d;
   logic        lapf_q, lapf_d;
   logic        wrap_q, wrap_d;

   logic [15:0] cnt_inc;
   logic        at_max;
   logic        counting;
   logic        step;

   // BCD +1 second with digit carries; terminal value folds to 00:00
   always_comb begin
      cnt_inc = cnt_q;
      at_max  = (cnt_q[15:8] == MIN_BCD) &&
                (cnt_q[7:0] == 8'h59);
      if (at_max) begin
         cnt_inc = 16'h0000;
      end else if (cnt_q[3:0] != 4'd9) begin
         cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
      end else begin
         cnt_inc[3:0] = 4'd0;
         if (cnt_q[7:4] != 4'd5) begin
            cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
         end else begin
            cnt_inc[7:4] = 4'd0;
            if (cnt_q[11:8] != 4'd9) begin
               cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
            end else begin
               cnt_inc[11:8]  = 4'd0;
               cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lap_d    = lap_q;
      pre_d    = pre_q;
      counting = (state_q == RUN) || (state_q == LAP);
      step     = counting && bus.tick && (pre_q == PRE_LAST);

      if (counting && bus.tick) begin
         pre_d = step ? 8'd0 : pre_q + 8'd1;
         if (step) cnt_d = cnt_inc;
      end

      // start_stop wins over lap_reset in the same cycle
      unique case (state_q)
         IDLE: begin
            if (bus.start_stop) state_d = RUN;
         end
         RUN: begin
            if (bus.start_stop) begin
               state_d = PAUSE;
            end else if (bus.lap_reset) begin
               state_d = LAP;
               lap_d   = cnt_q;
            end
         end
         LAP: begin
            if (bus.start_stop)     state_d = PAUSE;
            else if (bus.lap_reset) state_d = RUN;
         end
         PAUSE: begin
            if (bus.start_stop) begin
               state_d = RUN;
            end else if (bus.lap_reset) begin
               state_d = IDLE;
               cnt_d   = 16'h0000;
               pre_d   = 8'd0;
               lap_d   = 16'h0000;
            end
         end
         default: state_d = IDLE;
      endcase

      wrap_d = step && at_max;
      disp_d = (state_d == LAP) ? lap_d : cnt_d;
      run_d  = (state_d == RUN) || (state_d == LAP);
      lapf_d = (state_d == LAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 16'h0000;
         lap_q   <= 16'h0000;
         pre_q   <= 8'd0;
         disp_q  <= 16'h0000;
         run_q   <= 1'b0;
         lapf_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lap_q   <= lap_d;
         pre_q   <= pre_d;
         disp_q  <= disp_d;
         run_q   <= run_d;
         lapf_q  <= lapf_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.disp_bcd   = disp_q;
   assign bus.run        = run_q;
   assign bus.lap_frozen = lapf_q;
   assign bus.state      = state_q;
   assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (59/1 and 2/4) driven in lockstep
// and compared against a seconds-based reference model.
module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stopwatch_ctrl_if ifa ();
   stopwatch_ctrl_if ifb ();

   stopwatch_ctrl #(.MIN_MAX(59), .TICK_PRESCALE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   stopwatch_ctrl #(.MIN_MAX(2), .TICK_PRESCALE(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   int nvec = 0;
   int nerr = 0;
   int wcnt_a = 0;

   always @(negedge clk) if (ifa.wrap === 1'b1) wcnt_a++;

   typedef struct {
      int st;
      int secs;
      int lap;
      int pre;
      bit wrap;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset();
      mdl_t m;
      m.st = 0; m.secs = 0; m.lap = 0; m.pre = 0; m.wrap = 0;
      return m;
   endfunction

   // states: 0 idle, 1 run, 2 pause, 3 lap; time kept as total seconds
   function automatic mdl_t mstep(mdl_t m, bit ss, bit lr, bit tk,
                                  int mm, int p);
      mdl_t n = m;
      n.wrap = 0;
      if ((m.st == 1 || m.st == 3) && tk) begin
         n.pre = m.pre + 1;
         if (n.pre == p) begin
            n.pre = 0;
            n.secs = m.secs + 1;
            if (n.secs == (mm + 1) * 60) begin
               n.secs = 0;
               n.wrap = 1;
            end
         end
      end
      if (ss) begin
         case (m.st)
            0: n.st = 1;
            1: n.st = 2;
            2: n.st = 1;
            default: n.st = 2;
         endcase
      end else if (lr) begin
         case (m.st)
            1: begin n.st = 3; n.lap = m.secs; end
            3: n.st = 1;
            2: begin n.st = 0; n.secs = 0; n.pre = 0; n.lap = 0; end
            default: ;
         endcase
      end
      return n;
   endfunction

   function automatic logic [15:0] bcd(int s);
      int mi = s / 60;
      int se = s % 60;
      return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
   endfunction

   function automatic logic [20:0] mout(mdl_t m);
      logic [15:0] d = bcd(m.st == 3 ? m.lap : m.secs);
      return {d, 1'(m.st == 1 || m.st == 3), 1'(m.st == 3),
              2'(m.st), m.wrap};
   endfunction

   task automatic cyc(input bit ss, input bit lr, input bit tk);
      ifa.start_stop = ss; ifa.lap_reset = lr; ifa.tick = tk;
      ifb.start_stop = ss; ifb.lap_reset = lr; ifb.tick = tk;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         ma = mreset();
         mb = mreset();
      end else begin
         ma = mstep(ma, ss, lr, tk, 59, 1);
         mb = mstep(mb, ss, lr, tk, 2, 4);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         cyc(1'b0, 1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [20:0] oa, ob;
      do_reset();
      oa = {ifa.disp_bcd, ifa.run, ifa.lap_frozen, ifa.state, ifa.wrap};
      ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
      nvec++;
      if (oa !== 21'h0) begin
         nerr++; $display("FAIL reset_a: got %h want 0", oa);
      end
      nvec++;
      if (ob !== 21'h0) begin
         nerr++; $display("FAIL reset_b: got %h want 0", ob);
      end
   endtask

   task automatic test_count();
      logic [20:0] ob;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      ticks(75);
      nvec++;
      if (ifa.disp_bcd !== 16'h0115) begin
         nerr++; $display("FAIL count_disp: got %h want 0115", ifa.disp_bcd);
      end
      nvec++;
      if (ifa.state !== 2'd1 || ifa.run !== 1'b1) begin
         nerr++;
         $display("FAIL count_state: got %0d/%b want 1/1",
                  ifa.state, ifa.run);
      end
      ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
      nvec++;
      if (ob !== mout(mb)) begin
         nerr++; $display("FAIL count_b: got %h want %h", ob, mout(mb));
      end
   endtask

   task automatic test_wrap();
      logic [20:0] ob;
      int w0;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      w0 = wcnt_a;
      for (int i = 0; i < 3599; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
         nvec++;
         if (ob !== mout(mb)) begin
            nerr++;
            $display("FAIL wrap_b[%0d]: got %h want %h", i, ob, mout(mb));
         end
         cyc(1'b0, 1'b0, 1'b0);
      end
      nvec++;
      if (ifa.disp_bcd !== 16'h5959 || wcnt_a != w0) begin
         nerr++;
         $display("FAIL wrap_pre: got %h/%0d want 5959/0",
                  ifa.disp_bcd, wcnt_a - w0);
      end
      cyc(1'b0, 1'b0, 1'b1);
      nvec++;
      if (ifa.disp_bcd !== 16'h0000 || ifa.wrap !== 1'b1 ||
          ifa.state !== 2'd1) begin
         nerr++;
         $display("FAIL wrap_roll: got %h/%b/%0d want 0000/1/1",
                  ifa.disp_bcd, ifa.wrap, ifa.state);
      end
      cyc(1'b0, 1'b0, 1'b0);
      nvec++;
      if (ifa.wrap !== 1'b0 || wcnt_a - w0 != 1) begin
         nerr++;
         $display("FAIL wrap_once: got %b/%0d want 0/1",
                  ifa.wrap, wcnt_a - w0);
      end
   endtask

   task automatic test_lap();
      logic [20:0] ob;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      ticks(10);
      cyc(1'b0, 1'b1, 1'b0);
      ticks(5);
      nvec++;
      if (ifa.disp_bcd !== 16'h0010 || ifa.lap_frozen !== 1'b1 ||
          ifa.state !== 2'd3) begin
         nerr++;
         $display("FAIL lap_hold: got %h/%b/%0d want 0010/1/3",
                  ifa.disp_bcd, ifa.lap_frozen, ifa.state);
      end
      cyc(1'b0, 1'b1, 1'b0);
      nvec++;
      if (ifa.disp_bcd !== 16'h0015 || ifa.state !== 2'd1 ||
          ifa.lap_frozen !== 1'b0) begin
         nerr++;
         $display("FAIL lap_release: got %h/%0d want 0015/1",
                  ifa.disp_bcd, ifa.state);
      end
      ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
      nvec++;
      if (ob !== mout(mb)) begin
         nerr++; $display("FAIL lap_b: got %h want %h", ob, mout(mb));
      end
   endtask

   task automatic test_pause();
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      ticks(20);
      cyc(1'b1, 1'b0, 1'b1);
      nvec++;
      if (ifa.state !== 2'd2 || ifa.disp_bcd !== 16'h0021 ||
          ifa.run !== 1'b0) begin
         nerr++;
         $display("FAIL pause_enter: got %0d/%h want 2/0021",
                  ifa.state, ifa.disp_bcd);
      end
      ticks(10);
      nvec++;
      if (ifa.disp_bcd !== 16'h0021) begin
         nerr++; $display("FAIL pause_hold: got %h want 0021", ifa.disp_bcd);
      end
      cyc(1'b0, 1'b1, 1'b0);
      nvec++;
      if (ifa.state !== 2'd0 || ifa.disp_bcd !== 16'h0000) begin
         nerr++;
         $display("FAIL pause_clear: got %0d/%h want 0/0000",
                  ifa.state, ifa.disp_bcd);
      end
      cyc(1'b1, 1'b1, 1'b0);
      nvec++;
      if (ifa.state !== 2'd1 || ifa.lap_frozen !== 1'b0) begin
         nerr++;
         $display("FAIL pause_prio: got %0d/%b want 1/0",
                  ifa.state, ifa.lap_frozen);
      end
   endtask

   task automatic test_prescale();
      logic [20:0] oa;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      ticks(7);
      nvec++;
      if (ifb.disp_bcd !== 16'h0001) begin
         nerr++; $display("FAIL pre_7: got %h want 0001", ifb.disp_bcd);
      end
      cyc(1'b1, 1'b0, 1'b0);
      nvec++;
      if (ifb.state !== 2'd2) begin
         nerr++; $display("FAIL pre_pause: got %0d want 2", ifb.state);
      end
      cyc(1'b1, 1'b0, 1'b0);
      ticks(1);
      nvec++;
      if (ifb.disp_bcd !== 16'h0002 || ifb.state !== 2'd1) begin
         nerr++;
         $display("FAIL pre_resume: got %h/%0d want 0002/1",
                  ifb.disp_bcd, ifb.state);
      end
      oa = {ifa.disp_bcd, ifa.run, ifa.lap_frozen, ifa.state, ifa.wrap};
      nvec++;
      if (oa !== mout(ma)) begin
         nerr++; $display("FAIL pre_a: got %h want %h", oa, mout(ma));
      end
   endtask

   task automatic test_reset_mid();
      logic [20:0] oa, ob;
      int w0;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      ticks(207);
      cyc(1'b0, 1'b1, 1'b0);
      nvec++;
      if (ifa.disp_bcd !== 16'h0327 || ifa.lap_frozen !== 1'b1) begin
         nerr++;
         $display("FAIL rmid_lap: got %h/%b want 0327/1",
                  ifa.disp_bcd, ifa.lap_frozen);
      end
      w0 = wcnt_a;
      rst_n = 1'b0;
      #1;
      oa = {ifa.disp_bcd, ifa.run, ifa.lap_frozen, ifa.state, ifa.wrap};
      ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
      nvec++;
      if (oa !== 21'h0 || ob !== 21'h0) begin
         nerr++; $display("FAIL rmid_async: got %h/%h want 0/0", oa, ob);
      end
      cyc(1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      oa = {ifa.disp_bcd, ifa.run, ifa.lap_frozen, ifa.state, ifa.wrap};
      nvec++;
      if (oa !== 21'h0 || wcnt_a != w0) begin
         nerr++;
         $display("FAIL rmid_after: got %h/%0d want 0/0", oa, wcnt_a - w0);
      end
   endtask

   task automatic test_random();
      logic [20:0] oa, ob;
      bit ss, lr, tk;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         ss = ($urandom_range(0, 31) == 0);
         lr = ($urandom_range(0, 47) == 0);
         tk = ($urandom_range(0, 1) == 1);
         cyc(ss, lr, tk);
         oa = {ifa.disp_bcd, ifa.run, ifa.lap_frozen, ifa.state, ifa.wrap};
         ob = {ifb.disp_bcd, ifb.run, ifb.lap_frozen, ifb.state, ifb.wrap};
         nvec++;
         if (oa !== mout(ma)) begin
            nerr++;
            $display("FAIL rand_a[%0d]: got %h want %h", i, oa, mout(ma));
         end
         nvec++;
         if (ob !== mout(mb)) begin
            nerr++;
            $display("FAIL rand_b[%0d]: got %h want %h", i, ob, mout(mb));
         end
      end
   endtask

   initial begin
      ifa.tick = 1'b0; ifa.start_stop = 1'b0; ifa.lap_reset = 1'b0;
      ifb.tick = 1'b0; ifb.start_stop = 1'b0; ifb.lap_reset = 1'b0;
      ma = mreset();
      mb = mreset();
      test_reset();
      test_count();
      test_wrap();
      test_lap();
      test_pause();
      test_prescale();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
